fifo_puerto: RTL and testbench
==============================

# fifo_puerto

Synchronous show-ahead FIFO for one arbiter port of the transaction layer. Four instances sit on the arbiter's input side (the arbiter pops them, seeing `empty` and the head word), and four more sit on its output side (the arbiter pushes them, watching `almost_full`). The FIFO is the storage end of the arbiter's pop/empty and push/almost_full handshakes. It exposes the head word combinationally so the arbiter can route it in the same cycle it pops.

## Interface
- `FIFO_WORD_SIZE`, 10: word width in bits. Bits [9:8] are the destination field and are passed through unmodified.
- `FIFO_DEPTH`, 8: number of entries. Must be a power of two, at least 4.
- `ADDR_WIDTH`, 3: log2(FIFO_DEPTH).
- `ALMOST_FULL_TH`, 6: `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY_TH`, 2: `almost_empty` asserts when count <= this value.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write enable; `data_in` is stored at the edge.
- `data_in`  in  FIFO_WORD_SIZE  write word.
- `pop`  in  1  read enable; the head entry is removed at the edge.
- `data_out`  out  FIFO_WORD_SIZE  head word (show-ahead); 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == FIFO_DEPTH.
- `almost_full`  out  1  count >= ALMOST_FULL_TH.
- `almost_empty`  out  1  count <= ALMOST_EMPTY_TH.
- `count`  out  ADDR_WIDTH+1  current fill level, 0..FIFO_DEPTH.
- `error`  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- State: `wr_ptr` and `rd_ptr`, each ADDR_WIDTH bits, wrapping modulo FIFO_DEPTH; `count`, ADDR_WIDTH+1 bits; storage array; `error` register.
- Accepted push (push=1 and not full, or push=1 with full and an accepted pop): mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Accepted pop (pop=1 and not empty): rd_ptr <= rd_ptr+1.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Full with push and pop in the same cycle: both are accepted. Count stays FIFO_DEPTH and the head advances.
- Empty with push and pop in the same cycle: the push is accepted and the pop is ignored (underflow). Count becomes 1.
- Push while full without pop: the word is dropped and the pointers are unchanged (overflow).
- Pop while empty: ignored (underflow).
- `data_out` = mem[rd_ptr] when count != 0, else 0. It is a pure function of registered state.
- All flags decode from `count` only. There is no combinational path from `push`, `pop` or `data_in` to any output.
- Storage contents are not cleared by reset.

## Timing
- Reset: applies at the edge where `reset`=1 and overrides push and pop in that cycle. After reset: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, error=0.
- Write-to-read latency: a word pushed at edge N appears on `data_out` and `empty` falls after edge N. It can be popped at edge N+1.
- Pop: `data_out` shows the next entry after the popping edge.
- Flags change only at clock edges, in the same cycle `count` changes.
- Pointer wrap: after FIFO_DEPTH accepted pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.
- Reset asserted mid-stream discards all contents. The first push after reset is the next word out.

## Configuration
- Macro: `FIFO_PUERTO_ERR_EN`.
- Defined: `error` sets at the edge of any overflow or underflow event and stays 1 until `reset`.
- Not defined: `error` is constant 0 and no error register is synthesized. Data-path behaviour is identical in both cases.
- The behavioural and synthesized netlists are compared with the macro both defined and undefined.

## Test plan
- Reset, then push 10'h1A6, 10'h2B7, 10'h017 on consecutive cycles -> `empty` falls after the first edge; pops return 1A6, 2B7, 017 in order; `empty` =1 after the third pop.
- Push 6 words with default thresholds -> `almost_full` rises at the 6th push edge (count=6); one pop -> `almost_full` falls (count=5).
- Push 8 words, then push 10'h345 alone -> count stays 8, `full`=1, 10'h345 never appears on `data_out`, `error`=1 (only with `FIFO_PUERTO_ERR_EN`).
- Full FIFO, push 10'h145 and pop together -> count stays 8; after 8 further pops the last word out is 145. Covers pointer wrap.
- Empty FIFO, pop alone -> count 0, `data_out`=0, `error`=1 with the macro and 0 without it. Empty FIFO, push 10'h317 with pop -> count 1, `data_out`=317.
- Fill with 4 words, assert `reset` together with push and pop -> count 0, `empty`=1, `error`=0; the next push of 10'h0A6 is output first.

Source files
------------

// File: rtl/fifo_puerto.sv
// Synchronous show-ahead FIFO for one arbiter port; head word is visible combinationally from registered state.
// Optional sticky overflow/underflow flag enabled by defining FIFO_PUERTO_ERR_EN.
module fifo_puerto #(
  parameter int FIFO_WORD_SIZE  = 10,
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic                      pop_ok;
  logic                      push_ok;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != DEPTH_C) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= data_in;
  end

  assign data_out     = (count != '0) ? mem[rd_ptr] : '0;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

`ifdef FIFO_PUERTO_ERR_EN
  logic error_q;

  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else if ((push && !push_ok) || (pop && !pop_ok)) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_puerto.sv
// Bench for fifo_puerto: table vectors, directed corner sequences, and random traffic against a queue model.
module tb_fifo_puerto;
  localparam int W = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         empty, full, almost_full, almost_empty, error;
  logic [3:0]   count;

  fifo_puerto dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic err_m = 1'b0;

  typedef struct {
    logic         rst;
    logic         ps;
    logic         pp;
    logic [W-1:0] d;
    int           exp_count;
    logic [W-1:0] exp_dout;
    logic         exp_err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic en_err(input logic e);
`ifdef FIFO_PUERTO_ERR_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_model();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == D));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("data_out", 32'(data_out), (n != 0) ? 32'(q[0]) : 32'd0);
    chk("error", 32'(error), 32'(en_err(err_m)));
  endtask

  task automatic step(input logic r, input logic ps, input logic pp, input logic [W-1:0] d);
    bit pop_ok, push_ok;
    @(negedge clk);
    reset = r; push = ps; pop = pp; data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      pop_ok  = pp && (q.size() > 0);
      push_ok = ps && ((q.size() < D) || pop_ok);
      if ((ps && !push_ok) || (pp && !pop_ok)) err_m = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    #1 compare_model();
  endtask

  initial begin
    // rst ps pp data  count dout  err
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'h000, 0, 10'h000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 10'h1A6, 1, 10'h1A6, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 10'h2B7, 2, 10'h1A6, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 10'h017, 3, 10'h1A6, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 10'h000, 2, 10'h2B7, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 10'h000, 1, 10'h017, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 10'h000, 0, 10'h000, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 10'h000, 0, 10'h000, 1'b1};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].ps, tbl[i].pp, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_error", i), 32'(error), 32'(en_err(tbl[i].exp_err)));
    end

    // almost_full threshold crossing
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 10'(i + 3));
    chk("af_at_6", 32'(almost_full), 32'd1);
    step(0, 0, 1, 0);
    chk("af_at_5", 32'(almost_full), 32'd0);

    // overflow: dropped word never surfaces
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 10'(10'h010 + i));
    step(0, 1, 0, 10'h345);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_error", 32'(error), 32'(en_err(1'b1)));
    for (int i = 0; i < 8; i++) begin
      chk("ovf_head", 32'(data_out), 32'(10'h010 + i));
      step(0, 0, 1, 0);
    end
    chk("ovf_drained", 32'(empty), 32'd1);

    // full with simultaneous push/pop, then drain across the wrap
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 10'(10'h020 + i));
    step(0, 1, 1, 10'h145);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_head", 32'(data_out), 32'h021);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    chk("wrap_last", 32'(data_out), 32'h145);
    step(0, 0, 1, 0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // empty underflow and empty push+pop
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_dout", 32'(data_out), 32'd0);
    chk("unf_error", 32'(error), 32'(en_err(1'b1)));
    step(0, 1, 1, 10'h317);
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_dout", 32'(data_out), 32'h317);

    // reset overriding push and pop mid-stream
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'(10'h050 + i));
    step(1, 1, 1, 10'h3FF);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    step(0, 1, 0, 10'h0A6);
    chk("rst_first", 32'(data_out), 32'h0A6);

    // random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) < (100 - bias)),
           10'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
